myip_lite_master: RTL
=====================

MYIP_LITE_MASTER -- requirements
Module: myip_lite_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (32 only).
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port ARESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 SHALL have ports cmd_write in 1 (1=write), cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH, cmd_wstrb in DATA_WIDTH/8: command payload.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-008 SHALL have ports rsp_write out 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2: echoed type, read data (0 for writes), BRESP/RRESP.
REQ-009 SHALL have AXI4-Lite master ports M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY, standard widths and directions.
REQ-010 SHALL have ports busy out 1 (state != IDLE) and err_cnt out 16 (count of non-OKAY responses).

Function
REQ-011 SHALL use FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-012 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid&&cmd_ready, payload registered that cycle.
REQ-013 On accepted write: next cycle SHALL enter WR_REQ with AWVALID=1 and WVALID=1 asserted together.
REQ-014 In WR_REQ, AWVALID SHALL drop the cycle after AWREADY seen, WVALID likewise after WREADY; each tracked by its own done flag; either order or simultaneous acceptance legal.
REQ-015 When both done flags set, SHALL enter WR_RESP with BREADY=1; on BVALID capture BRESP, go RSP.
REQ-016 On accepted read: SHALL enter RD_REQ with ARVALID=1; on ARREADY go RD_DATA with RREADY=1; on RVALID capture RDATA/RRESP, go RSP.
REQ-017 AxVALID and WVALID once asserted SHALL hold with stable payload until their READY (no withdrawal).
REQ-018 AWPROT and ARPROT SHALL be constant 3'b000; AWADDR/ARADDR SHALL be cmd_addr unmodified.
REQ-019 In RSP, rsp_valid=1 with stable payload until rsp_ready; then IDLE; rsp_valid&&rsp_ready and new cmd_valid same cycle: command accepted next cycle only.
REQ-020 BREADY/RREADY SHALL be 1 only in WR_RESP/RD_DATA respectively.
REQ-021 Minimum latency with always-ready slave: cmd accept -> rsp_valid = 3 cycles (write and read).
REQ-022 err_cnt SHALL increment when a response with resp != 2'b00 is captured, and SHALL saturate at 16'hFFFF.
REQ-023 Only one transaction SHALL be outstanding at a time.

Reset
REQ-024 While ARESET=1 SHALL hold state IDLE; cmd_ready=0; all VALID/READY outputs 0; rsp_rdata, rsp_resp, rsp_write, AxADDR, WDATA, WSTRB 0; err_cnt 0; busy 0.
REQ-025 ARESET mid-transaction SHALL abort immediately to IDLE without a response; cmd_ready=1 from first clock after deassertion.

Structure
REQ-026 State enum and response codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) SHALL live in package myip_lite_pkg.
REQ-027 SHALL be a single module; no sub-modules.

Verification
REQ-028 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC of myip_lite slave, read back -> rsp_rdata 0x1..0x4, rsp_resp 0, err_cnt 0.
REQ-029 Slave drives AWREADY 3 cycles after WREADY, then reverse -> each VALID drops exactly after its own handshake; one rsp_valid per command.
REQ-030 BRESP=2'b10 on one write -> rsp_resp 2'b10, err_cnt 1.
REQ-031 rsp_ready held 0 for 5 cycles -> rsp_valid and payload stable, cmd_ready 0 throughout.
REQ-032 ARESET pulse while in RD_DATA -> RREADY 0, rsp_valid never asserted, cmd_ready 1 after release.
REQ-033 Always-ready slave, back-to-back writes -> rsp_valid exactly 3 cycles after each command acceptance.

Source files
------------

// File: rtl/myip_lite_pkg.sv
// Shared definitions for the myip_lite AXI4-Lite command master.
//   state_t      : master FSM states
//   RESP_*       : AXI4-Lite BRESP/RRESP codes
//   is_err_resp  : true for any response other than OKAY
//   sat_inc16    : 16-bit increment that saturates at 16'hFFFF
package myip_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic is_err_resp(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/myip_lite_master_if.sv
// AXI4-Lite bus bundle for the myip_lite master.
//   master modport : drives AW/W/AR channels and BREADY/RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY and the B/R channels
// The master module itself keeps flat M_AXI_* ports; this bundle is
// what a system or bench uses to wire a slave to those ports.
interface myip_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/myip_lite_master.sv
// myip_lite_master: turns single-beat commands into AXI4-Lite transactions,
// one outstanding at a time, and returns one response per command.
//   ACLK, ARESET        : clock, asynchronous active-high reset
//   cmd_*               : command handshake + payload (write/addr/wdata/wstrb)
//   rsp_*               : response handshake + payload (write/rdata/resp)
//   M_AXI_*             : AXI4-Lite master channels
//   busy                : FSM not in IDLE
//   err_cnt             : saturating count of non-OKAY responses
module myip_lite_master
  import myip_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,

  output logic                            busy,
  output logic [15:0]                     err_cnt
);

  state_t state;
  state_t state_nxt;

  logic                            write_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                      resp_q;
  logic                            aw_done;
  logic                            w_done;

  logic cmd_fire;
  logic aw_fire;
  logic w_fire;
  logic b_capture;
  logic r_capture;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_fire   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire    = M_AXI_WVALID && M_AXI_WREADY;
  assign b_capture = (state == WR_RESP) && M_AXI_BVALID;
  assign r_capture = (state == RD_DATA) && M_AXI_RVALID;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // The write-request exit test uses READY directly rather than the fire
  // terms: while a done flag is clear its VALID is known to be high, and
  // this keeps the VALID outputs out of their own combinational cone.
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !ARESET;
        if (cmd_valid && !ARESET) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = RSP;
      end
      RD_REQ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      err_cnt <= '0;
    end else begin
      if (cmd_fire) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (b_capture) begin
        rdata_q <= '0;
        resp_q  <= M_AXI_BRESP;
        if (is_err_resp(M_AXI_BRESP)) err_cnt <= sat_inc16(err_cnt);
      end else if (r_capture) begin
        rdata_q <= M_AXI_RDATA;
        resp_q  <= M_AXI_RRESP;
        if (is_err_resp(M_AXI_RRESP)) err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;

  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state != IDLE);

endmodule
